// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_ctrl
// Brief   : EX-stage multiply/divide sequencer and HI/LO register owner.
//           Define MULDIV_PERF_CNT_EN to add stall/op performance counters.
// Revision: 1.0
// ============================================================================
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        ex_hold,
  input  logic        flush,
  output logic        stallreq,
  output logic        mul_start,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
`ifdef MULDIV_PERF_CNT_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_op_cnt,
`endif
  output logic        busy
);

  localparam logic [2:0] c_OP_MULT  = 3'd1;
  localparam logic [2:0] c_OP_MULTU = 3'd2;
  localparam logic [2:0] c_OP_DIV   = 3'd3;
  localparam logic [2:0] c_OP_DIVU  = 3'd4;
  localparam logic [2:0] c_OP_MTHI  = 3'd5;
  localparam logic [2:0] c_OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_WAIT = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic        r_consumed;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic        r_signed;

  logic        w_accept;
  logic        w_cap_ops;
  logic        w_hi_we;
  logic        w_lo_we;
  logic [31:0] w_hi_d;
  logic [31:0] w_lo_d;

  // consumed blocks re-issue of an instruction still frozen in EX after DONE
  assign w_accept = op_valid && !r_consumed && !rst;

  always_comb begin
    w_next_state = r_state;
    stallreq     = 1'b0;
    mul_start    = 1'b0;
    mul_signed   = 1'b0;
    mul_ina      = 32'd0;
    mul_inb      = 32'd0;
    div_start    = 1'b0;
    div_signed   = 1'b0;
    div_opa      = 32'd0;
    div_opb      = 32'd0;
    div_annul    = 1'b0;
    w_cap_ops    = 1'b0;
    w_hi_we      = 1'b0;
    w_lo_we      = 1'b0;
    w_hi_d       = r_hi;
    w_lo_d       = r_lo;
    if (flush) begin
      w_next_state = S_IDLE;
      div_annul    = (r_state == S_DIV_WAIT);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (op)
              c_OP_MULT, c_OP_MULTU: begin
                stallreq     = 1'b1;
                mul_start    = 1'b1;
                mul_signed   = (op == c_OP_MULT);
                mul_ina      = src_a;
                mul_inb      = src_b;
                w_cap_ops    = 1'b1;
                w_next_state = S_MUL_WAIT;
              end
              c_OP_DIV, c_OP_DIVU: begin
                stallreq = 1'b1;
                if (src_b != 32'd0) begin
                  div_start    = 1'b1;
                  div_signed   = (op == c_OP_DIV);
                  div_opa      = src_a;
                  div_opb      = src_b;
                  w_cap_ops    = 1'b1;
                  w_next_state = S_DIV_WAIT;
                end else begin
                  // divide by zero resolves locally without touching the divider
                  w_hi_we      = 1'b1;
                  w_lo_we      = 1'b1;
                  w_hi_d       = src_a;
                  w_lo_d       = 32'hFFFF_FFFF;
                  w_next_state = S_DONE;
                end
              end
              c_OP_MTHI: begin
                w_hi_we = 1'b1;
                w_hi_d  = src_a;
              end
              c_OP_MTLO: begin
                w_lo_we = 1'b1;
                w_lo_d  = src_a;
              end
              default: ;
            endcase
          end
        end
        S_MUL_WAIT: begin
          stallreq   = 1'b1;
          mul_signed = r_signed;
          mul_ina    = r_opa;
          mul_inb    = r_opb;
          if (r_cnt == 4'd1) begin
            w_hi_we      = 1'b1;
            w_lo_we      = 1'b1;
            w_hi_d       = mul_result[63:32];
            w_lo_d       = mul_result[31:0];
            w_next_state = S_DONE;
          end
        end
        S_DIV_WAIT: begin
          stallreq   = 1'b1;
          div_signed = r_signed;
          div_opa    = r_opa;
          div_opb    = r_opb;
          if (div_ready) begin
            w_hi_we      = 1'b1;
            w_lo_we      = 1'b1;
            w_hi_d       = div_result[63:32];
            w_lo_d       = div_result[31:0];
            w_next_state = S_DONE;
          end else begin
            div_start = 1'b1;
          end
        end
        S_DONE:  w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_consumed <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_opa      <= 32'd0;
      r_opb      <= 32'd0;
      r_signed   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_cap_ops) begin
        r_opa    <= src_a;
        r_opb    <= src_b;
        r_signed <= (op == c_OP_MULT) || (op == c_OP_DIV);
      end
      if (flush) begin
        r_cnt <= 4'd0;
      end else if (w_cap_ops && (w_next_state == S_MUL_WAIT)) begin
        r_cnt <= 4'(MUL_LAT);
      end else if ((r_state == S_MUL_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_hi_we) r_hi <= w_hi_d;
      if (w_lo_we) r_lo <= w_lo_d;
      if (flush) begin
        r_consumed <= 1'b0;
      end else if (((r_state == S_IDLE) || (r_state == S_DONE)) && !ex_hold) begin
        r_consumed <= 1'b0;
      end else if (r_state == S_DONE) begin
        r_consumed <= 1'b1;
      end
    end
  end

`ifdef MULDIV_PERF_CNT_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_op_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall_cnt <= 32'd0;
      r_perf_op_cnt    <= 32'd0;
    end else begin
      if (stallreq) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if ((w_next_state == S_DONE) && (r_state != S_DONE)) r_perf_op_cnt <= r_perf_op_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
  assign perf_op_cnt    = r_perf_op_cnt;
`endif

  assign hi_o = r_hi;
  assign lo_o = r_lo;
  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_muldiv_ctrl
// Brief   : Directed self-checking bench for muldiv_ctrl with a result scoreboard.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        ex_hold;
  logic        flush;
  logic        stallreq;
  logic        mul_start;
  logic        mul_signed;
  logic [31:0] mul_ina;
  logic [31:0] mul_inb;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_opa;
  logic [31:0] div_opb;
  logic        div_annul;
  logic        div_ready;
  logic [63:0] div_result;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy;
`ifdef MULDIV_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_op_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb_q[$];
  int          n_mul_start = 0;
  int          n_div_start = 0;
  logic [63:0] m_prod = 64'd0;
  int          m_cnt = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .ex_hold    (ex_hold),
    .flush      (flush),
    .stallreq   (stallreq),
    .mul_start  (mul_start),
    .mul_signed (mul_signed),
    .mul_ina    (mul_ina),
    .mul_inb    (mul_inb),
    .mul_result (mul_result),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_opa    (div_opa),
    .div_opb    (div_opb),
    .div_annul  (div_annul),
    .div_ready  (div_ready),
    .div_result (div_result),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
`ifdef MULDIV_PERF_CNT_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_op_cnt    (perf_op_cnt),
`endif
    .busy       (busy)
  );

  // Fixed-latency multiplier model: result valid only MUL_LAT cycles after start
  always @(posedge clk) begin
    if (mul_start) begin
      m_prod <= {{32{mul_signed & mul_ina[31]}}, mul_ina} * {{32{mul_signed & mul_inb[31]}}, mul_inb};
      m_cnt  <= MUL_LAT;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
    if (mul_start) n_mul_start <= n_mul_start + 1;
    if (div_start) n_div_start <= n_div_start + 1;
  end
  assign mul_result = (m_cnt == 1) ? m_prod : 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int maxcyc, output int stalls);
    stalls = 0;
    for (int i = 0; i < maxcyc; i++) begin
      if (busy && !stallreq) return;
      if (stallreq) stalls++;
      step();
      #1;
    end
    chk("done_timeout", {63'd0, busy && !stallreq}, 64'd1);
  endtask

  task automatic pop_cmp(input string tag);
    logic [63:0] exp;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
    end else begin
      exp = sb_q.pop_front();
      chk(tag, {hi_o, lo_o}, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   stalls;
    int   base;
    logic ok;
    rst = 1'b1; op_valid = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    ex_hold = 1'b0; flush = 1'b0; div_ready = 1'b0; div_result = 64'd0;
    step(); step(); #1;
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    chk("rst_ctl", {busy, stallreq, mul_start, div_start, div_annul}, 64'd0);
    rst = 1'b0;
    step();

    // mult -3 * 5
    op_valid = 1'b1; op = 3'd1; src_a = 32'hFFFF_FFFD; src_b = 32'd5; #1;
    chk("t1_issue", {stallreq, mul_start, mul_signed, div_start}, 64'b1110);
    chk("t1_ops", {mul_ina, mul_inb}, {32'hFFFF_FFFD, 32'd5});
    sb_q.push_back(64'hFFFF_FFFF_FFFF_FFF1);
    wait_done(20, stalls);
    op_valid = 1'b0; op = 3'd0;
    chk("t1_stalls", stalls, 3);
    pop_cmp("t1_result");
    step(); #1;
    chk("t1_mul_start_cnt", n_mul_start, 1);
    chk("t1_idle", busy, 0);

    // divu 100 / 7, divider ready 33 cycles after issue
    op_valid = 1'b1; op = 3'd4; src_a = 32'd100; src_b = 32'd7; #1;
    chk("t2_issue", {stallreq, div_start, div_signed, mul_start}, 64'b1100);
    chk("t2_ops", {div_opa, div_opb}, {32'd100, 32'd7});
    sb_q.push_back({32'd2, 32'd14});
    ok = 1'b1;
    for (int i = 1; i < 33; i++) begin
      step(); #1;
      if (!(stallreq && div_start && !div_annul && div_opa == 32'd100 && div_opb == 32'd7)) ok = 1'b0;
    end
    chk("t2_wait_hold", ok, 1);
    step(); div_ready = 1'b1; div_result = {32'd2, 32'd14}; #1;
    chk("t2_ready_cycle", {stallreq, div_start}, 64'b10);
    step(); div_ready = 1'b0; op_valid = 1'b0; op = 3'd0; #1;
    chk("t2_done", {busy, stallreq}, 64'b10);
    pop_cmp("t2_result");
    step(); #1;

    // div 9 / 0
    base = n_div_start;
    op_valid = 1'b1; op = 3'd3; src_a = 32'd9; src_b = 32'd0; #1;
    chk("t3_issue", {stallreq, div_start}, 64'b10);
    sb_q.push_back({32'd9, 32'hFFFF_FFFF});
    wait_done(5, stalls);
    op_valid = 1'b0; op = 3'd0;
    chk("t3_stalls", stalls, 1);
    pop_cmp("t3_result");
    step(); #1;
    chk("t3_no_div_start", n_div_start, base);

    // multu 7 * 6, then EX frozen 4 cycles with the op still present
    base = n_mul_start;
    op_valid = 1'b1; op = 3'd2; src_a = 32'd7; src_b = 32'd6;
    sb_q.push_back({32'd0, 32'd42});
    #1;
    wait_done(20, stalls);
    ex_hold = 1'b1;
    pop_cmp("t4_result");
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      if (mul_start || stallreq || busy || hi_o != 32'd0 || lo_o != 32'd42) ok = 1'b0;
    end
    chk("t4_hold_quiet", ok, 1);
    ex_hold = 1'b0; op_valid = 1'b0; op = 3'd0;
    step(); #1;
    chk("t4_single_issue", n_mul_start - base, 1);

    // mthi / mtlo, then flush a divide in flight with a coincident div_ready
    op_valid = 1'b1; op = 3'd5; src_a = 32'h1234; #1;
    chk("t5_mthi_nostall", {stallreq, busy}, 64'd0);
    step(); op = 3'd6; src_a = 32'h5678; #1;
    chk("t5_hi", hi_o, 32'h1234);
    step(); op_valid = 1'b0; op = 3'd0; #1;
    chk("t5_hilo", {hi_o, lo_o}, {32'h1234, 32'h5678});
    op_valid = 1'b1; op = 3'd3; src_a = 32'd50; src_b = 32'd3; #1;
    chk("t5_div_issue", {div_start, div_signed}, 64'b11);
    ok = 1'b1;
    for (int i = 1; i < 10; i++) begin
      step(); #1;
      if (div_annul || !stallreq) ok = 1'b0;
    end
    chk("t5_no_annul", ok, 1);
    step(); flush = 1'b1; div_ready = 1'b1; div_result = 64'hDEAD_0000_BEEF_0000; #1;
    chk("t5_flush", {div_annul, stallreq, div_start}, 64'b100);
    step(); flush = 1'b0; div_ready = 1'b0; op_valid = 1'b0; op = 3'd0; #1;
    chk("t5_idle", {busy, div_annul}, 64'd0);
    chk("t5_retain", {hi_o, lo_o}, {32'h1234, 32'h5678});

    // multu max * max
    op_valid = 1'b1; op = 3'd2; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
    sb_q.push_back(64'hFFFF_FFFE_0000_0001);
    #1;
    chk("t6_unsigned", mul_signed, 0);
    wait_done(20, stalls);
    op_valid = 1'b0; op = 3'd0;
    pop_cmp("t6_result");
    step(); #1;

    // mtlo
    op_valid = 1'b1; op = 3'd6; src_a = 32'hA5A5_A5A5; #1;
    chk("t7_nostall", stallreq, 0);
    step(); op_valid = 1'b0; op = 3'd0; #1;
    chk("t7_lo", lo_o, 32'hA5A5_A5A5);
    chk("t7_hi_kept", hi_o, 32'hFFFF_FFFE);

    // reset during MUL_WAIT
    op_valid = 1'b1; op = 3'd1; src_a = 32'd3; src_b = 32'd4; #1;
    step(); #1;
    chk("t8_mulwait", {busy, stallreq, mul_start}, 64'b110);
    rst = 1'b1;
    step(); op_valid = 1'b0; op = 3'd0; #1;
    chk("t8_rst_hilo", {hi_o, lo_o}, 64'd0);
    chk("t8_rst_ctl", {busy, stallreq}, 64'd0);
    rst = 1'b0;
    step(); #1;

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for the EX-stage multiply/divide resources and owner of the HI/LO register pair.
- Takes mult/multu/div/divu/mthi/mtlo requests from EX and issues them to the fixed-latency multiplier or the iterative divider (start/ready handshake).
- Raises the EX stall request while a unit is busy, then commits the 64-bit result into HI/LO.
- Handles flush/annul and the re-issue hazard while EX is frozen by another stall source.

Parameters:
- MUL_LAT, 2, multiplier latency in cycles from mul_start to valid mul_result (legal 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- op_valid  in  1  EX holds a muldiv-class op this cycle
- op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- src_a  in  32  rs operand
- src_b  in  32  rt operand
- ex_hold  in  1  EX register frozen by another stall source (stall[2]==Stop)
- flush  in  1  kill the op currently in EX
- stallreq  out  1  stall request to the pipeline controller
- mul_start  out  1  one-cycle issue pulse to the multiplier
- mul_signed  out  1  signed multiply
- mul_ina  out  32  multiplier operand A
- mul_inb  out  32  multiplier operand B
- mul_result  in  64  {hi,lo} product
- div_start  out  1  held high until div_ready
- div_signed  out  1  signed divide
- div_opa  out  32  dividend
- div_opb  out  32  divisor
- div_annul  out  1  abort the divider
- div_ready  in  1  divider result valid
- div_result  in  64  {remainder, quotient}
- hi_o  out  32  architectural HI
- lo_o  out  32  architectural LO
- busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; hi_o=lo_o=0; counter=0; consumed=0; every output 0.
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- IDLE, op_valid, consumed=0, op in {mult, multu}:
  - stallreq=1 combinationally; mul_start=1; operands driven; mul_signed=(op==mult).
  - Next state MUL_WAIT, counter=MUL_LAT.
- MUL_WAIT:
  - stallreq=1; operands held stable from internal operand registers.
  - Counter decrements each cycle.
  - In the cycle counter==1: capture HI=mul_result[63:32], LO=mul_result[31:0] at the edge; next state DONE.
  - Issue at cycle t gives HI/LO visible at t+MUL_LAT+1.
- IDLE, div/divu with src_b!=0:
  - stallreq=1; div_start=1; div_signed=(op==div); next state DIV_WAIT.
- DIV_WAIT:
  - stallreq=1; div_start and operands held.
  - On div_ready=1: LO=div_result[31:0], HI=div_result[63:32]; div_start=0 that cycle; next state DONE.
- Divide by zero (src_b==0):
  - Divider not started; stallreq=1 for the issue cycle only.
  - Commit HI=src_a, LO=32'hFFFFFFFF; next state DONE.
- DONE: stallreq=0; consumed set to 1; next state IDLE.
- consumed flag:
  - Cleared in any cycle with ex_hold=0 while in IDLE or DONE.
  - While consumed=1, an op_valid in IDLE is ignored, so the same frozen instruction is never re-issued.
- mthi/mtlo in IDLE, consumed=0:
  - HI (resp. LO) = src_a at the edge; no stall; no state change.
  - Repeated writes under ex_hold are permitted (idempotent).
- flush:
  - Highest priority in any state: next state IDLE, HI/LO not written, consumed=0.
  - div_annul=1 for that cycle if the state is DIV_WAIT, 0 otherwise.
  - stallreq=0 in the flush cycle.
- Reset mid-operation: same as the reset values; div_annul is not required.
- Simultaneous div_ready and flush: flush wins, no commit.
- Operand widths: full 32x32->64. No truncation; sign handling is left to the external units.

Optional Feature:
- MULDIV_PERF_CNT_EN
- Defined:
  - Adds output perf_stall_cnt[31:0] and output perf_op_cnt[31:0].
  - perf_stall_cnt increments every cycle stallreq=1; perf_op_cnt increments on every DONE entry.
  - Both wrap at 2^32 and are cleared by rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- mult src_a=-3 (32'hFFFFFFFD), src_b=5, MUL_LAT=2 -> stallreq high 3 cycles; hi_o=32'hFFFFFFFF, lo_o=32'hFFFFFFF1 in DONE; mul_start single pulse.
- divu 100/7, model divider ready after 33 cycles -> stallreq high until the ready cycle; lo_o=14, hi_o=2; div_start drops in the ready cycle.
- div src_a=9, src_b=0 -> no div_start; 1 stall cycle; hi_o=9, lo_o=32'hFFFFFFFF.
- mult completes, ex_hold=1 for 4 cycles after DONE with op_valid still high -> no second mul_start, stallreq stays 0, HI/LO unchanged.
- div in DIV_WAIT, flush at cycle 10 -> div_annul=1 that cycle, state IDLE, hi_o/lo_o retain prior values 32'h1234/32'h5678.
- mtlo src_a=32'hA5A5A5A5, then mfhi path read -> lo_o=32'hA5A5A5A5 next cycle, stallreq never asserted; rst during MUL_WAIT -> hi_o=lo_o=0, busy=0.
